mips_inst_encoder: RTL and testbench

MIPS_INST_ENCODER -- requirements
Module: mips_inst_encoder

---
 rtl/mips_enc_pkg.sv | 17 +
 rtl/mips_inst_encoder_if.sv | 19 +
 rtl/mips_enc_fifo.sv | 38 +++
 rtl/mips_inst_encoder.sv | 56 +++++
 tb/tb_mips_inst_encoder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_enc_pkg.sv
// mips_enc_pkg: op enum, opcode/funct constants and instruction field positions for the MIPS encoder
package mips_enc_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_AND, OP_OR, OP_NOR, OP_SLL, OP_SRL, OP_ADDI, OP_ILL} op_e;
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] FN_ADD    = 6'b100000;
  localparam logic [5:0] FN_AND    = 6'b100100;
  localparam logic [5:0] FN_OR     = 6'b100101;
  localparam logic [5:0] FN_NOR    = 6'b100111;
  localparam logic [5:0] FN_SLL    = 6'b000000;
  localparam logic [5:0] FN_SRL    = 6'b000010;
  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int SH_LSB  = 6;
endpackage

// File: rtl/mips_inst_encoder_if.sv
// mips_inst_encoder_if: request (in_*) and response (out_*) handshake bus; master drives requests, slave is the encoder
interface mips_inst_encoder_if;
  import mips_enc_pkg::*;
  logic        in_valid;
  logic        in_ready;
  op_e         in_op;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  modport master (output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
                  input in_ready, out_valid, out_instr);
  modport slave  (input in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_imm, out_ready,
                  output in_ready, out_valid, out_instr);
endinterface

// File: rtl/mips_enc_fifo.sv
// mips_enc_fifo: DEPTH-entry 32-bit synchronous FIFO; ports clk, rst, push_i, pop_i, wdata_i, rdata_o (0 when empty), level_o, full_o, empty_o
module mips_enc_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   level_q;
  logic          we, re;
  assign full_o  = level_q == (AW+1)'(DEPTH);
  assign empty_o = level_q == '0;
  assign we      = push_i && !full_o;
  assign re      = pop_i && !empty_o;
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(we);
      rptr_q  <= rptr_q + AW'(re);
      level_q <= level_q + (AW+1)'(we) - (AW+1)'(re);
    end
  end
  always_ff @(posedge clk) if (we) mem_q[wptr_q] <= wdata_i;
endmodule

// File: rtl/mips_inst_encoder.sv
// mips_inst_encoder: encodes ALU/shift/ADDI requests into MIPS words queued in a FIFO; ports clk, rst, bus (slave), level, err, issued_cnt; macro MIPS_ENC_CNT_EN builds the pop counter
module mips_inst_encoder
  import mips_enc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  mips_inst_encoder_if.slave     bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err,
  output logic [15:0]            issued_cnt
);
  logic [31:0] instr;
  logic [5:0]  fn;
  logic        is_sh, full, empty, accept, push, pop, err_d, err_q;
  always_comb begin
    fn = bus.in_op == OP_AND ? FN_AND :
         bus.in_op == OP_OR  ? FN_OR  :
         bus.in_op == OP_NOR ? FN_NOR :
         bus.in_op == OP_SLL ? FN_SLL :
         bus.in_op == OP_SRL ? FN_SRL : FN_ADD;
    is_sh = bus.in_op == OP_SLL || bus.in_op == OP_SRL;
    instr = bus.in_op == OP_ADDI
      ? (32'(OPC_ADDI) << OPC_LSB) | (32'(bus.in_rs) << RS_LSB) | (32'(bus.in_rt) << RT_LSB) | 32'(bus.in_imm)
      : (32'(OPC_RTYPE) << OPC_LSB) | (32'(is_sh ? 5'd0 : bus.in_rs) << RS_LSB) | (32'(bus.in_rt) << RT_LSB)
        | (32'(bus.in_rd) << RD_LSB) | (32'(is_sh ? bus.in_shamt : 5'd0) << SH_LSB) | 32'(fn);
  end
  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign accept = bus.in_valid && !full;
  assign push   = accept && bus.in_op != OP_ILL;
  assign pop    = !empty && bus.out_ready;
  assign err_d  = accept && bus.in_op == OP_ILL;
  assign err    = err_q;
  always_ff @(posedge clk) err_q <= rst ? 1'b0 : err_d;
  mips_enc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (instr),
    .rdata_o (bus.out_instr),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );
`ifdef MIPS_ENC_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  assign cnt_d      = cnt_q + 16'(pop);
  assign issued_cnt = cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
`else
  assign issued_cnt = '0;
`endif
endmodule

// File: tb/tb_mips_inst_encoder.sv
// tb_mips_inst_encoder: directed self-checking bench for mips_inst_encoder
module tb_mips_inst_encoder;
  import mips_enc_pkg::*;
`ifdef MIPS_ENC_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  level;
  logic        err;
  logic [15:0] issued_cnt;
  int          n_chk = 0;
  int          n_fail = 0;
  int          exp_cnt = 0;
  mips_inst_encoder_if bus();
  mips_inst_encoder #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .level      (level),
    .err        (err),
    .issued_cnt (issued_cnt)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input op_e op, input logic [4:0] rs, rt, rd, sh, input logic [15:0] imm, input bit v);
    bus.in_op    = op;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_shamt = sh;
    bus.in_imm   = imm;
    bus.in_valid = v;
  endtask
  function automatic logic [15:0] want_cnt(input int n);
    return CNT_EN ? 16'(n) : 16'd0;
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    bus.out_ready = 1'b0;
    drive(OP_ADD, 0, 0, 0, 0, 0, 1'b0);
    step();
    step();
    rst = 1'b0;
    n_chk++;
    if (level !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_instr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_state level=%0d out_valid=%b out_instr=%h want 0/0/0", level, bus.out_valid, bus.out_instr);
    end
    n_chk++;
    if (err !== 1'b0 || issued_cnt !== 16'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_flags err=%b issued=%0d in_ready=%b want 0/0/1", err, issued_cnt, bus.in_ready);
    end
  endtask
  task automatic test_encoding();
    op_e         ops [7] = '{OP_ADD, OP_ADDI, OP_SLL, OP_AND, OP_OR, OP_NOR, OP_SRL};
    logic [4:0]  rs  [7] = '{13, 17, 31, 1, 4, 7, 5};
    logic [4:0]  rt  [7] = '{14, 2, 27, 2, 5, 8, 10};
    logic [4:0]  rd  [7] = '{1, 9, 3, 3, 6, 9, 11};
    logic [4:0]  sh  [7] = '{9, 9, 4, 5, 1, 2, 31};
    logic [15:0] imm [7] = '{16'hFFFF, 16'd5, 16'h1234, 0, 0, 0, 0};
    logic [31:0] exp [7] = '{32'h01AE0820, 32'h22220005, 32'h001B1900, 32'h00221824,
                             32'h00853025, 32'h00E84827, 32'h000A5FC2};
    for (int i = 0; i < 7; i++) begin
      bus.out_ready = 1'b0;
      drive(ops[i], rs[i], rt[i], rd[i], sh[i], imm[i], 1'b1);
      n_chk++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL enc_no_bypass[%0d] out_valid=%b want 0", i, bus.out_valid);
      end
      step();
      bus.in_valid = 1'b0;
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== exp[i]) begin
        n_fail++;
        $display("FAIL enc_word[%0d] out_valid=%b out_instr=%h want 1/%h", i, bus.out_valid, bus.out_instr, exp[i]);
      end
      bus.out_ready = 1'b1;
      step();
      exp_cnt++;
      bus.out_ready = 1'b0;
      n_chk++;
      if (level !== 3'd0 || issued_cnt !== want_cnt(exp_cnt)) begin
        n_fail++;
        $display("FAIL enc_pop[%0d] level=%0d issued=%0d want 0/%0d", i, level, issued_cnt, want_cnt(exp_cnt));
      end
    end
  endtask
  task automatic test_illegal();
    drive(OP_ILL, 3, 4, 5, 6, 16'h00AA, 1'b1);
    n_chk++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pre err=%b want 0", err);
    end
    step();
    bus.in_valid = 1'b0;
    n_chk++;
    if (err !== 1'b1 || level !== 3'd0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse err=%b level=%0d out_valid=%b want 1/0/0", err, level, bus.out_valid);
    end
    step();
    n_chk++;
    if (err !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear err=%b out_valid=%b want 0/0", err, bus.out_valid);
    end
  endtask
  task automatic test_full();
    logic [31:0] exp [5];
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp[i] = 32'h20000000 + 32'(i + 100);
      drive(OP_ADDI, 0, 0, 0, 0, 16'(i + 100), 1'b1);
      n_chk++;
      if (bus.in_ready !== (i < 4)) begin
        n_fail++;
        $display("FAIL full_in_ready[%0d] in_ready=%b want %b", i, bus.in_ready, i < 4);
      end
      step();
    end
    n_chk++;
    if (level !== 3'd4 || bus.in_ready !== 1'b0 || bus.out_instr !== exp[0]) begin
      n_fail++;
      $display("FAIL full_state level=%0d in_ready=%b head=%h want 4/0/%h", level, bus.in_ready, bus.out_instr, exp[0]);
    end
    bus.out_ready = 1'b1;
    step();
    exp_cnt++;
    bus.in_valid = 1'b0;
    n_chk++;
    if (level !== 3'd3 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_only level=%0d in_ready=%b want 3/1", level, bus.in_ready);
    end
    for (int k = 1; k < 4; k++) begin
      n_chk++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== exp[k]) begin
        n_fail++;
        $display("FAIL full_order[%0d] out_valid=%b out_instr=%h want 1/%h", k, bus.out_valid, bus.out_instr, exp[k]);
      end
      step();
      exp_cnt++;
    end
    bus.out_ready = 1'b0;
    n_chk++;
    if (level !== 3'd0 || bus.out_valid !== 1'b0 || issued_cnt !== want_cnt(exp_cnt)) begin
      n_fail++;
      $display("FAIL full_drained level=%0d out_valid=%b issued=%0d want 0/0/%0d", level, bus.out_valid, issued_cnt, want_cnt(exp_cnt));
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] q [$];
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      drive(OP_ADD, 0, 0, 5'(k), 0, 0, 1'b1);
      q.push_back((32'(k) << 11) | 32'h20);
      step();
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      drive(OP_ADD, 0, 0, 5'(c + 2), 0, 0, 1'b1);
      q.push_back((32'(c + 2) << 11) | 32'h20);
      n_chk++;
      if (level !== 3'd2 || bus.out_instr !== q[0]) begin
        n_fail++;
        $display("FAIL b2b[%0d] level=%0d out_instr=%h want 2/%h", c, level, bus.out_instr, q[0]);
      end
      step();
      void'(q.pop_front());
      exp_cnt++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_chk++;
    if (level !== 3'd2 || issued_cnt !== want_cnt(20) || bus.out_instr !== q[0]) begin
      n_fail++;
      $display("FAIL b2b_end level=%0d issued=%0d head=%h want 2/%0d/%h", level, issued_cnt, bus.out_instr, want_cnt(20), q[0]);
    end
  endtask
  task automatic test_mid_reset();
    bus.out_ready = 1'b0;
    drive(OP_OR, 1, 2, 3, 0, 0, 1'b1);
    step();
    n_chk++;
    if (level !== 3'd3) begin
      n_fail++;
      $display("FAIL midrst_pre level=%0d want 3", level);
    end
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    exp_cnt = 0;
    n_chk++;
    if (level !== 3'd0 || bus.out_valid !== 1'b0 || issued_cnt !== 16'd0 || bus.in_ready !== 1'b1 || bus.out_instr !== 32'd0) begin
      n_fail++;
      $display("FAIL midrst_post level=%0d out_valid=%b issued=%0d in_ready=%b out_instr=%h want 0/0/0/1/0",
               level, bus.out_valid, issued_cnt, bus.in_ready, bus.out_instr);
    end
  endtask
  initial begin
    test_reset();
    test_encoding();
    test_illegal();
    test_full();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
